fix_msg_serializer: RTL and testbench
=====================================

// Module: fix_msg_serializer
// PURPOSE
//  Parametrised FIX message serializer. Accepts one tag/value field per handshake
//  and emits "tag=value<SOH>" as a byte stream with valid/ready flow control.
//  On the field flagged last it appends the computed trailer "10=ddd<SOH>", where
//  ddd is the byte sum mod 256. Sits between the field builder and the TX byte path.
// PARAMETERS
//  TAG_BYTES  4      max tag length in bytes (ASCII)
//  VAL_BYTES  16     max value length in bytes (ASCII)
//  SOH        8'h01  field delimiter byte
//  TLEN_W     $clog2(TAG_BYTES+1)  width of tag_len_i
//  VLEN_W     $clog2(VAL_BYTES+1)  width of val_len_i
// PORTS
//  clk           in   1              clock
//  rst           in   1              asynchronous reset, active-low
//  field_valid_i in   1              field presented
//  field_ready_o out  1              field accepted when valid&ready
//  tag_i         in   8*TAG_BYTES    tag ASCII, byte 0 = bits[7:0], sent first
//  tag_len_i     in   TLEN_W         tag byte count
//  val_i         in   8*VAL_BYTES    value ASCII, byte 0 = bits[7:0], sent first
//  val_len_i     in   VLEN_W         value byte count
//  last_i        in   1              field is last in message; trailer follows
//  abort_i       in   1              synchronous message abort
//  data_o        out  8              output byte
//  data_valid_o  out  1              data_o valid
//  data_ready_i  in   1              sink accepts byte when valid&ready
//  eom_o         out  1              qualifies final trailer SOH byte
//  checksum_o    out  8              running checksum (mod 256)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, field_ready_o=1, data_valid_o=0, data_o=0,
//    eom_o=0, checksum_o=0, all field/length/index registers cleared.
//  - States: IDLE, TAG, EQ, VAL, FSOH, CK1, CK0, CKEQ, CKD2, CKD1, CKD0, CKSOH.
//  - field_ready_o=1 only in IDLE. Handshake in IDLE latches tag_i, val_i, lengths,
//    last_i; data_valid_o rises next cycle with byte 0 of tag (1-cycle latency).
//  - All outputs registered. A byte advances only on data_valid_o&data_ready_i;
//    while stalled, data_o/eom_o hold stable and data_valid_o stays 1.
//  - TAG: bytes 0..tlen-1 -> EQ (8'h3D) -> VAL: bytes 0..vlen-1 -> FSOH (SOH).
//    After FSOH: last=0 -> IDLE; last=1 -> CK1.
//  - Length rules: tag_len_i 0 treated as 1; tag_len_i>TAG_BYTES clamps to TAG_BYTES;
//    val_len_i>VAL_BYTES clamps; val_len_i 0 skips VAL (EQ -> FSOH directly).
//  - Checksum: on every accepted byte in TAG/EQ/VAL/FSOH, checksum += byte,
//    8-bit wrap. Trailer bytes are not summed.
//  - Trailer: CK1 '1'(31), CK0 '0'(30), CKEQ '='(3D), CKD2/D1/D0 ASCII of
//    checksum/100, (checksum/10)%10, checksum%10 with leading zeros, CKSOH SOH
//    with eom_o=1. Checksum frozen during trailer; cleared to 0 on CKSOH accept;
//    state -> IDLE.
//  - Next field may be accepted in the cycle after the final FSOH/CKSOH accept
//    (one IDLE cycle between fields).
//  - abort_i=1: next edge -> IDLE, data_valid_o=0, eom_o=0, checksum_o=0;
//    takes priority over any handshake that cycle. Ignored-effect in IDLE
//    except checksum clear.
//  - Async reset mid-message: stream truncated immediately; next message
//    checksum starts from 0.
//  - field_valid_i while not ready is held by the source; inputs are sampled only
//    at handshake.
// TESTING
//  - Field tag "35"(len 2), val "D"(len 1), last=1, data_ready_i=1 -> bytes
//    33 35 3D 44 01 31 30 3D 32 33 34 01 ("35=D|10=234|"), eom_o on last byte only.
//  - Same message with data_ready_i randomly low 50% -> identical byte sequence;
//    data_o stable throughout every stall.
//  - Message whose summed bytes wrap past 255 to 7 -> trailer digits 30 30 37;
//    checksum_o returns to 0 after CKSOH.
//  - tag_len_i=0 -> one tag byte; val_len_i=VAL_BYTES+3 -> exactly VAL_BYTES value
//    bytes; val_len_i=0 -> "tag=" then SOH, no value bytes.
//  - Drive rst=0 mid-VAL -> data_valid_o=0 asynchronously; next "35=D" last
//    message trailer again 234.
//  - abort_i during CKD1 stall -> IDLE next cycle, no further bytes, next message
//    checksum computed from 0.

Source files
------------

// File: rtl/fix_msg_serializer.sv
// FIX field serializer: emits "tag=value<SOH>" per accepted field and, on the last
// field of a message, the trailer "10=ddd<SOH>" carrying the byte sum mod 256.
module fix_msg_serializer #(
    parameter int          TAG_BYTES = 4,
    parameter int          VAL_BYTES = 16,
    parameter logic [7:0]  SOH       = 8'h01,
    parameter int          TLEN_W    = $clog2(TAG_BYTES + 1),
    parameter int          VLEN_W    = $clog2(VAL_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   field_valid_i,
    output logic                   field_ready_o,
    input  logic [8*TAG_BYTES-1:0] tag_i,
    input  logic [TLEN_W-1:0]      tag_len_i,
    input  logic [8*VAL_BYTES-1:0] val_i,
    input  logic [VLEN_W-1:0]      val_len_i,
    input  logic                   last_i,
    input  logic                   abort_i,
    output logic [7:0]             data_o,
    output logic                   data_valid_o,
    input  logic                   data_ready_i,
    output logic                   eom_o,
    output logic [7:0]             checksum_o
);

    localparam int CNT_W = (TLEN_W > VLEN_W) ? TLEN_W : VLEN_W;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_TAG   = 4'd1;
    localparam logic [3:0] S_EQ    = 4'd2;
    localparam logic [3:0] S_VAL   = 4'd3;
    localparam logic [3:0] S_FSOH  = 4'd4;
    localparam logic [3:0] S_CK1   = 4'd5;
    localparam logic [3:0] S_CK0   = 4'd6;
    localparam logic [3:0] S_CKEQ  = 4'd7;
    localparam logic [3:0] S_CKD2  = 4'd8;
    localparam logic [3:0] S_CKD1  = 4'd9;
    localparam logic [3:0] S_CKD0  = 4'd10;
    localparam logic [3:0] S_CKSOH = 4'd11;

    localparam logic [7:0]        ASCII_0 = 8'h30;
    localparam logic [7:0]        ASCII_1 = 8'h31;
    localparam logic [7:0]        ASCII_EQ = 8'h3D;
    localparam logic [TLEN_W-1:0] TAG_MAX = TLEN_W'(TAG_BYTES);
    localparam logic [VLEN_W-1:0] VAL_MAX = VLEN_W'(VAL_BYTES);

    logic [3:0]             r_state;
    logic [8*TAG_BYTES-1:0] r_tag;
    logic [8*VAL_BYTES-1:0] r_val;
    logic [VLEN_W-1:0]      r_vlen;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_last;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_eom;
    logic [7:0]             r_chk;

    logic [TLEN_W-1:0]      w_tlen;
    logic [VLEN_W-1:0]      w_vlen;
    logic                   w_accept;
    logic                   w_summed;

    always_comb begin
        w_tlen = tag_len_i;
        if (tag_len_i == '0)
            w_tlen = TLEN_W'(1);
        else if (tag_len_i > TAG_MAX)
            w_tlen = TAG_MAX;
        w_vlen = (val_len_i > VAL_MAX) ? VAL_MAX : val_len_i;
    end

    assign w_accept = r_valid & data_ready_i;
    assign w_summed = (r_state == S_TAG) || (r_state == S_EQ) ||
                      (r_state == S_VAL) || (r_state == S_FSOH);

    // r_tag/r_val shift right as bytes go out; r_cnt counts bytes still queued behind r_data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_tag   <= '0;
            r_val   <= '0;
            r_vlen  <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_eom   <= 1'b0;
            r_chk   <= '0;
        end else if (abort_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_eom   <= 1'b0;
            r_chk   <= '0;
        end else if (r_state == S_IDLE) begin
            if (field_valid_i) begin
                r_tag   <= tag_i >> 8;
                r_val   <= val_i;
                r_vlen  <= w_vlen;
                r_cnt   <= CNT_W'(w_tlen - TLEN_W'(1));
                r_last  <= last_i;
                r_data  <= tag_i[7:0];
                r_valid <= 1'b1;
                r_state <= S_TAG;
            end
        end else if (w_accept) begin
            if (w_summed)
                r_chk <= r_chk + r_data;
            case (r_state)
                S_TAG: begin
                    if (r_cnt != '0) begin
                        r_data <= r_tag[7:0];
                        r_tag  <= r_tag >> 8;
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end else begin
                        r_data  <= ASCII_EQ;
                        r_state <= S_EQ;
                    end
                end
                S_EQ: begin
                    if (r_vlen == '0) begin
                        r_data  <= SOH;
                        r_state <= S_FSOH;
                    end else begin
                        r_data  <= r_val[7:0];
                        r_val   <= r_val >> 8;
                        r_cnt   <= CNT_W'(r_vlen - VLEN_W'(1));
                        r_state <= S_VAL;
                    end
                end
                S_VAL: begin
                    if (r_cnt != '0) begin
                        r_data <= r_val[7:0];
                        r_val  <= r_val >> 8;
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end else begin
                        r_data  <= SOH;
                        r_state <= S_FSOH;
                    end
                end
                S_FSOH: begin
                    if (r_last) begin
                        r_data  <= ASCII_1;
                        r_state <= S_CK1;
                    end else begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_CK1: begin
                    r_data  <= ASCII_0;
                    r_state <= S_CK0;
                end
                S_CK0: begin
                    r_data  <= ASCII_EQ;
                    r_state <= S_CKEQ;
                end
                // r_chk already includes the final field SOH and stays frozen from here
                S_CKEQ: begin
                    r_data  <= ASCII_0 + r_chk / 8'd100;
                    r_state <= S_CKD2;
                end
                S_CKD2: begin
                    r_data  <= ASCII_0 + (r_chk / 8'd10) % 8'd10;
                    r_state <= S_CKD1;
                end
                S_CKD1: begin
                    r_data  <= ASCII_0 + r_chk % 8'd10;
                    r_state <= S_CKD0;
                end
                S_CKD0: begin
                    r_data  <= SOH;
                    r_eom   <= 1'b1;
                    r_state <= S_CKSOH;
                end
                S_CKSOH: begin
                    r_valid <= 1'b0;
                    r_eom   <= 1'b0;
                    r_chk   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_eom   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign field_ready_o = (r_state == S_IDLE);
    assign data_o        = r_data;
    assign data_valid_o  = r_valid;
    assign eom_o         = r_eom;
    assign checksum_o    = r_chk;

endmodule

// File: tb/tb_fix_msg_serializer.sv
// Directed bench for fix_msg_serializer: byte streams, stalls, length clamping,
// checksum wrap, async reset and abort recovery.
module tb_fix_msg_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         field_valid_i = 1'b0;
    logic         field_ready_o;
    logic [31:0]  tag_i = '0;
    logic [2:0]   tag_len_i = '0;
    logic [127:0] val_i = '0;
    logic [4:0]   val_len_i = '0;
    logic         last_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [7:0]   data_o;
    logic         data_valid_o;
    logic         data_ready_i = 1'b1;
    logic         eom_o;
    logic [7:0]   checksum_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] q_exp[$];

    always #5 clk = ~clk;

    fix_msg_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .field_valid_i(field_valid_i),
        .field_ready_o(field_ready_o),
        .tag_i        (tag_i),
        .tag_len_i    (tag_len_i),
        .val_i        (val_i),
        .val_len_i    (val_len_i),
        .last_i       (last_i),
        .abort_i      (abort_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .eom_o        (eom_o),
        .checksum_o   (checksum_o)
    );

    task automatic send_field(input logic [31:0] t, input logic [2:0] tl,
                              input logic [127:0] v, input logic [4:0] vl, input logic l);
        int cyc = 0;
        @(negedge clk);
        while (!field_ready_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (field_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: field_ready_o=%b required 1", field_ready_o);
        end
        tag_i = t; tag_len_i = tl; val_i = v; val_len_i = vl; last_i = l;
        field_valid_i = 1'b1;
        @(posedge clk);
        #1 field_valid_i = 1'b0;
    endtask

    // Collects q_exp.size() accepted bytes; checks order, eom and stall stability.
    task automatic collect(input bit rnd, input bit has_trailer, input bit chk_end, input string nm);
        int n = q_exp.size();
        int got = 0;
        int cyc = 0;
        logic [7:0] pd = '0;
        logic pv = 1'b0;
        logic pr = 1'b1;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (pv && !pr) begin
                total++;
                if (data_o !== pd || data_valid_o !== 1'b1) begin
                    bad++;
                    $display("FAIL %s stall_hold: data_o=%h valid=%b required %h valid 1", nm, data_o, data_valid_o, pd);
                end
            end
            data_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (data_valid_o && data_ready_i) begin
                total++;
                if (data_o !== q_exp[got]) begin
                    bad++;
                    $display("FAIL %s byte%0d: got %h required %h", nm, got, data_o, q_exp[got]);
                end
                total++;
                if (eom_o !== (has_trailer && got == n - 1)) begin
                    bad++;
                    $display("FAIL %s eom%0d: got %b required %b", nm, got, eom_o, has_trailer && got == n - 1);
                end
                got++;
            end
            pv = data_valid_o; pd = data_o; pr = data_ready_i;
        end
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL %s timeout: got %0d bytes required %0d", nm, got, n);
        end
        data_ready_i = 1'b1;
        if (chk_end) begin
            @(negedge clk);
            total++;
            if (data_valid_o !== 1'b0 || field_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL %s end_idle: valid=%b ready=%b required 0/1", nm, data_valid_o, field_ready_o);
            end
        end
    endtask

    task automatic run_basic(input bit rnd, input string nm);
        send_field(32'h3533, 3'd2, 128'h44, 5'd1, 1'b1);
        q_exp = '{8'h33, 8'h35, 8'h3D, 8'h44, 8'h01, 8'h31, 8'h30, 8'h3D, 8'h32, 8'h33, 8'h34, 8'h01};
        collect(rnd, 1'b1, 1'b1, nm);
        total++;
        if (checksum_o !== 8'h00) begin
            bad++;
            $display("FAIL %s chk_clear: got %h required 00", nm, checksum_o);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (field_ready_o !== 1'b1 || data_valid_o !== 1'b0 || data_o !== 8'h00 ||
            eom_o !== 1'b0 || checksum_o !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h eom=%b chk=%h required 1 0 00 0 00",
                     field_ready_o, data_valid_o, data_o, eom_o, checksum_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (field_ready_o !== 1'b1 || data_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b valid=%b required 1 0", field_ready_o, data_valid_o);
        end
    endtask

    task automatic test_basic();
        run_basic(1'b0, "basic");
    endtask

    task automatic test_stall();
        run_basic(1'b1, "stall");
    endtask

    task automatic test_wrap();
        // 0x39+0x3D+0x48+0x48+0x01 = 263 -> 7
        send_field(32'h39, 3'd1, 128'h4848, 5'd2, 1'b1);
        q_exp = '{8'h39, 8'h3D, 8'h48, 8'h48, 8'h01, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h30, 8'h37, 8'h01};
        collect(1'b0, 1'b1, 1'b1, "wrap");
        total++;
        if (checksum_o !== 8'h00) begin
            bad++;
            $display("FAIL wrap_chk_clear: got %h required 00", checksum_o);
        end
    endtask

    task automatic test_lengths();
        send_field(32'h4241, 3'd0, 128'h31, 5'd1, 1'b0);
        q_exp = '{8'h41, 8'h3D, 8'h31, 8'h01};
        collect(1'b0, 1'b0, 1'b1, "tlen0");
        total++;
        if (checksum_o !== 8'd176) begin
            bad++;
            $display("FAIL tlen0_chk: got %0d required 176", checksum_o);
        end
        send_field(32'h41, 3'd1, 128'h46454443_42413938_37363534_33323130, 5'd19, 1'b0);
        q_exp = '{8'h41, 8'h3D, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                  8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h01};
        collect(1'b0, 1'b0, 1'b1, "vclamp");
        // running sum 176 + 1057 + 128 = 1361 -> 81
        send_field(32'h42, 3'd1, 128'h0, 5'd0, 1'b1);
        q_exp = '{8'h42, 8'h3D, 8'h01, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h38, 8'h31, 8'h01};
        collect(1'b0, 1'b1, 1'b1, "vlen0");
    endtask

    task automatic test_reset_mid();
        send_field(32'h3533, 3'd2, 128'h44444444, 5'd4, 1'b1);
        q_exp = '{8'h33, 8'h35, 8'h3D};
        collect(1'b0, 1'b0, 1'b0, "rstmid_pre");
        @(negedge clk);
        total++;
        if (data_o !== 8'h44 || data_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_inval: data=%h valid=%b required 44 1", data_o, data_valid_o);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (data_valid_o !== 1'b0 || checksum_o !== 8'h00 || field_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_async: valid=%b chk=%h ready=%b required 0 00 1",
                     data_valid_o, checksum_o, field_ready_o);
        end
        @(negedge clk);
        rst = 1'b1;
        run_basic(1'b0, "after_rst");
    endtask

    task automatic test_abort();
        send_field(32'h3533, 3'd2, 128'h44, 5'd1, 1'b1);
        q_exp = '{8'h33, 8'h35, 8'h3D, 8'h44, 8'h01, 8'h31, 8'h30, 8'h3D, 8'h32};
        collect(1'b0, 1'b0, 1'b0, "abort_pre");
        @(negedge clk);
        data_ready_i = 1'b0;
        total++;
        if (data_o !== 8'h33 || data_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL abort_ckd1: data=%h valid=%b required 33 1", data_o, data_valid_o);
        end
        @(negedge clk);
        abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        @(negedge clk);
        total++;
        if (data_valid_o !== 1'b0 || eom_o !== 1'b0 || checksum_o !== 8'h00 || field_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle: valid=%b eom=%b chk=%h ready=%b required 0 0 00 1",
                     data_valid_o, eom_o, checksum_o, field_ready_o);
        end
        data_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (data_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet%0d: valid=%b required 0", i, data_valid_o);
            end
        end
        run_basic(1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_lengths();
        test_reset_mid();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
